// File: rtl/matrix_addsub_pipe.sv
// matrix_addsub_pipe
//   Two-stage, lane-parallel signed add/subtract for packed matrix rows.
//   Stage 1 widens each lane to W+1 bits and adds or subtracts. Stage 2
//   detects overflow and then either wraps the result or saturates it.
//
// Handshake: a beat moves across an interface on a rising edge where valid
// and ready are both high. A producer keeps valid high until that transfer
// happens. While out_valid is high and out_ready is low, m_out, ovf_lanes
// and ovf hold their values. in_ready depends combinationally on out_ready
// and on nothing else from the inputs.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready operand beat handshake
//   op                0 = m1+m2, 1 = m1-m2 (captured per beat)
//   sat_en            1 = saturate on overflow, 0 = wrap (captured per beat)
//   m1, m2            packed operands, lane 0 in the most significant W bits
//   out_valid/out_ready result beat handshake
//   m_out             packed result, same packing as the operands
//   ovf_lanes         per-lane overflow, lane 0 in the MSB
//   ovf               OR of ovf_lanes
//   ovf_sticky        set by any overflowed beat, cleared by clr_sticky
//   clr_sticky        clear request for ovf_sticky (a set on the same cycle wins)
module matrix_addsub_pipe #(
  parameter int LANES = 5,
  parameter int W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               op,
  input  logic               sat_en,
  input  logic [LANES*W-1:0] m1,
  input  logic [LANES*W-1:0] m2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] m_out,
  output logic [LANES-1:0]   ovf_lanes,
  output logic               ovf,
  output logic               ovf_sticky,
  input  logic               clr_sticky
);

  localparam int RW = W + 1;

  // Stage 1 registers
  logic                   s1_valid_q;
  logic                   s1_sat_q;
  logic [LANES*RW-1:0]    s1_res_q;
  logic [LANES*RW-1:0]    s1_res_d;

  // Stage 2 registers
  logic                   out_valid_q;
  logic [LANES*W-1:0]     m_out_q;
  logic [LANES*W-1:0]     m_out_d;
  logic [LANES-1:0]       ovf_lanes_q;
  logic [LANES-1:0]       ovf_lanes_d;
  logic                   sticky_q;
  logic                   sticky_d;

  logic                   s1_en;
  logic                   s2_en;

  // A stage may advance when it is empty or when the stage after it advances.
  assign s2_en    = !out_valid_q || out_ready;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_ready = s1_en;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [RW-1:0] ax;
    logic [RW-1:0] bx;
    logic [RW-1:0] q;
    logic          lane_ovf;
    logic [W-1:0]  sat_val;

    assign a  = m1[(LANES-g)*W-1 -: W];
    assign b  = m2[(LANES-g)*W-1 -: W];
    // With one extra bit the sum or difference of two W-bit values cannot overflow.
    assign ax = {a[W-1], a};
    assign bx = {b[W-1], b};
    assign s1_res_d[(LANES-g)*RW-1 -: RW] = op ? (ax - bx) : (ax + bx);

    assign q        = s1_res_q[(LANES-g)*RW-1 -: RW];
    // The result fits in W bits only while the top two bits agree.
    assign lane_ovf = q[W] ^ q[W-1];
    // q[W] is the true sign. It selects the most positive or most negative value.
    assign sat_val  = q[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    assign m_out_d[(LANES-g)*W-1 -: W] = (lane_ovf && s1_sat_q) ? sat_val : q[W-1:0];
    assign ovf_lanes_d[LANES-1-g]      = lane_ovf;
  end

  always_comb begin
    sticky_d = sticky_q;
    if (s2_en && s1_valid_q && (|ovf_lanes_d)) begin
      sticky_d = 1'b1;
    end else if (clr_sticky) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sat_q    <= 1'b0;
      s1_res_q    <= '0;
      out_valid_q <= 1'b0;
      m_out_q     <= '0;
      ovf_lanes_q <= '0;
      sticky_q    <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
      if (s1_en) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_sat_q <= sat_en;
          s1_res_q <= s1_res_d;
        end
      end
      if (s2_en) begin
        // When stage 1 holds a bubble, out_valid drops and the old data stays.
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          m_out_q     <= m_out_d;
          ovf_lanes_q <= ovf_lanes_d;
        end
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign m_out      = m_out_q;
  assign ovf_lanes  = ovf_lanes_q;
  assign ovf        = |ovf_lanes_q;
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_matrix_addsub_pipe.sv
// Testbench for matrix_addsub_pipe (LANES = 5, W = 8).
// An integer-arithmetic model predicts each accepted beat. A negedge
// compare process retires results against that model and checks that the
// outputs hold during stalls. Directed tests also pin a few literal results.
module tb_matrix_addsub_pipe;

  localparam int LANES = 5;
  localparam int W     = 8;
  localparam int DW    = LANES * W;

  typedef logic [DW+LANES-1:0] exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             op;
  logic             sat_en;
  logic [DW-1:0]    m1;
  logic [DW-1:0]    m2;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    m_out;
  logic [LANES-1:0] ovf_lanes;
  logic             ovf;
  logic             ovf_sticky;
  logic             clr_sticky;

  matrix_addsub_pipe #(.LANES(LANES), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .sat_en     (sat_en),
    .m1         (m1),
    .m2         (m2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .m_out      (m_out),
    .ovf_lanes  (ovf_lanes),
    .ovf        (ovf),
    .ovf_sticky (ovf_sticky),
    .clr_sticky (clr_sticky)
  );

  // ---------------- bookkeeping ----------------
  int   n_vec     = 0;
  int   n_err     = 0;
  int   n_retired = 0;
  logic saw_stall = 1'b0;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pack5(input int e0, input int e1, input int e2,
                                          input int e3, input int e4);
    logic [DW-1:0] r;
    int e [LANES];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4;
    for (int i = 0; i < LANES; i++) r[(LANES-i)*W-1 -: W] = e[i][W-1:0];
    return r;
  endfunction

  // Reference model: exact integer result, then either clamp or wrap.
  function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic o, input logic s);
    logic [DW-1:0]    res;
    logic [LANES-1:0] ovl;
    int mx;
    int mn;
    mx = (1 << (W-1)) - 1;
    mn = -(1 << (W-1));
    for (int i = 0; i < LANES; i++) begin
      int x;
      int y;
      int r;
      logic ov;
      x  = $signed(a[(LANES-i)*W-1 -: W]);
      y  = $signed(b[(LANES-i)*W-1 -: W]);
      r  = o ? (x - y) : (x + y);
      ov = (r > mx) || (r < mn);
      if (ov && s) r = (r > mx) ? mx : mn;
      res[(LANES-i)*W-1 -: W] = r[W-1:0];
      ovl[LANES-1-i] = ov;
    end
    return {res, ovl};
  endfunction

  // ---------------- scoreboard / compare process ----------------
  logic        hold_pend = 1'b0;
  logic [63:0] hold_val;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("stall_hold", {18'd0, out_valid, m_out, ovf_lanes}, hold_val);
        hold_pend = 1'b0;
      end
      if (in_valid && !in_ready) saw_stall = 1'b1;
      if (in_valid && in_ready) exp_q.push_back(model(m1, m2, op, sat_en));
      if (out_valid) begin
        if (!out_ready) begin
          hold_pend = 1'b1;
          hold_val  = {18'd0, 1'b1, m_out, ovf_lanes};
        end else if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got m_out %h with no beat outstanding (t=%0t)", m_out, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("m_out",     m_out,     e[DW+LANES-1:LANES]);
          chk("ovf_lanes", ovf_lanes, e[LANES-1:0]);
          chk("ovf",       ovf,       |e[LANES-1:0]);
          n_retired++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Holds the beat on the inputs until it is accepted. waits counts stalled cycles.
  task automatic drive(input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic o, input logic s, output int waits);
    m1 = a; m2 = b; op = o; sat_en = s; in_valid = 1'b1;
    waits = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        step();
        return;
      end
      waits++;
    end
    n_vec++;
    n_err++;
    $display("FAIL drive_timeout: got in_ready low for 100 cycles, expected acceptance");
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 100; k++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    chk("drain", exp_q.size(), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int w;
    int start_ret;
    logic seen;
    logic [DW-1:0] a_ov;
    logic [DW-1:0] b_ov;

    rst = 1'b1; in_valid = 1'b1; op = 1'b0; sat_en = 1'b0; out_ready = 1'b1;
    clr_sticky = 1'b0;
    m1 = pack5(1, 2, 3, 4, 5); m2 = pack5(1, 1, 1, 1, 1);

    // Reset with in_valid held high: nothing may be accepted.
    repeat (5) step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_m_out", m_out, 0);
    chk("rst_ovf_lanes", ovf_lanes, 0);
    chk("rst_sticky", ovf_sticky, 0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    step();
    chk("post_rst_out_valid", out_valid, 0);

    // Model pins: hand-computed lane results.
    a_ov = pack5(100, -100, 127, -128, 50);
    b_ov = pack5(30, 30, 1, -1, -100);
    chk("model_pin_wrap", model(a_ov, b_ov, 1'b0, 1'b0), {pack5(-126, -70, -128, 127, -50), 5'b10110});
    chk("model_pin_sat",  model(a_ov, b_ov, 1'b0, 1'b1), {pack5(127, -70, 127, -128, -50), 5'b10110});
    // 0-(-128)=128, -128-1=-129 and 127-(-1)=128 overflow; 5-5=0 and -1-127=-128 fit.
    chk("model_pin_sub", model(pack5(0, -128, 127, 5, -1), pack5(-128, 1, -1, 5, 127), 1'b1, 1'b1),
        {pack5(127, -128, 127, 0, -128), 5'b11100});

    // Add, wrap, no overflow. The result must appear exactly two cycles after acceptance.
    drive(pack5(10, -20, 30, -40, 50), pack5(-5, 15, -25, 35, -45), 1'b0, 1'b0, w);
    idle();
    chk("latency_early", out_valid, 0);
    step();
    chk("add_valid", out_valid, 1);
    chk("add_m_out", m_out, pack5(5, -5, 5, -5, 5));
    chk("add_ovf_lanes", ovf_lanes, 5'b00000);
    chk("add_ovf", ovf, 0);
    chk("add_sticky", ovf_sticky, 0);
    step();

    // Add with overflow, wrap mode.
    drive(a_ov, b_ov, 1'b0, 1'b0, w);
    idle();
    step();
    chk("ovw_m_out", m_out, pack5(-126, -70, -128, 127, -50));
    chk("ovw_ovf_lanes", ovf_lanes, 5'b10110);
    chk("ovw_ovf", ovf, 1);
    chk("ovw_sticky", ovf_sticky, 1);
    step();

    // Add with overflow, saturate mode.
    drive(a_ov, b_ov, 1'b0, 1'b1, w);
    idle();
    step();
    chk("ovs_m_out", m_out, pack5(127, -70, 127, -128, -50));
    chk("ovs_ovf_lanes", ovf_lanes, 5'b10110);
    step();

    // Subtract edge cases with saturation.
    drive(pack5(0, -128, 127, 5, -1), pack5(-128, 1, -1, 5, 127), 1'b1, 1'b1, w);
    idle();
    step();
    chk("sub_m_out", m_out, pack5(127, -128, 127, 0, -128));
    chk("sub_ovf_lanes", ovf_lanes, 5'b11100);
    step();

    // Full throughput: with out_ready high every beat is accepted without a stall.
    for (int i = 0; i < 4; i++) begin
      drive(pack5(i*7, -i*9, 60 + i*20, -3*i, i), pack5(i, 2*i, 30, 40, -i), i[0], i[1], w);
      chk("no_bubble", w, 0);
    end
    idle();
    wait_drain();

    // Backpressure: six beats while out_ready follows the pattern 1,0,0,1.
    start_ret = n_retired;
    saw_stall = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          drive(pack5(13*i - 40, 100 - 25*i, i, -128 + i, 127 - i),
                pack5(20 + i, 30 * i, -i, 3, -3), i[0], i[1], w);
        end
        idle();
      end
      begin
        for (int c = 0; c < 40; c++) begin
          out_ready = ((c % 4) == 0) || ((c % 4) == 3);
          step();
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("bp_retired", n_retired - start_ret, 6);
    chk("bp_in_ready_dropped", saw_stall, 1);

    // Sticky: a clear on an idle cycle takes effect.
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    chk("sticky_idle_clear", ovf_sticky, 0);
    // A clear on the same cycle as an overflowed beat loads into stage 2: the set wins.
    drive(a_ov, b_ov, 1'b0, 1'b0, w);
    idle();
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    chk("sticky_set_wins", ovf_sticky, 1);
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    chk("sticky_clear_after", ovf_sticky, 0);
    wait_drain();

    // Mid-stream reset with two beats in flight.
    out_ready = 1'b0;
    drive(pack5(1, 2, 3, 4, 5), pack5(5, 4, 3, 2, 1), 1'b0, 1'b0, w);
    drive(pack5(9, 9, 9, 9, 9), pack5(1, 1, 1, 1, 1), 1'b1, 1'b0, w);
    idle();
    rst = 1'b1;
    step();
    chk("midrst_out_valid", out_valid, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_no_ghost", seen, 0);
    chk("midrst_in_ready", in_ready, 1);

    wait_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
